// File: rtl/paddle_bank.sv
//------------------------------------------------------------------------------
// paddle_bank : N-channel quadrature front end (debounce, decode, paddle pos/bitmap)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module paddle_bank #(
  parameter  int NCH     = 2,
  parameter  int ROWS    = 16,
  parameter  int PLEN    = 3,
  parameter  int DEB_LEN = 9,
  parameter  int DEB_DIV = 7,
  localparam int PW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      enc_a,
  input  logic [NCH-1:0]      enc_b,
  input  logic [NCH-1:0]      recenter,
  input  logic                freeze,
  output logic [NCH-1:0]      step_up,
  output logic [NCH-1:0]      step_dn,
  output logic [NCH*PW-1:0]   pos,
  output logic [NCH*ROWS-1:0] paddle_o
);

  localparam int MAXPOS = ROWS - PLEN;
  localparam int CENTER = MAXPOS / 2;
  localparam int DW     = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  localparam logic [PW-1:0] MAXPOS_P = PW'(MAXPOS);
  localparam logic [PW-1:0] CENTER_P = PW'(CENTER);

  function automatic logic [ROWS-1:0] bitmap(input logic [PW-1:0] p);
    logic [ROWS-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) begin
      m[r] = (r >= int'(p)) && (r < int'(p) + PLEN);
    end
    return m;
  endfunction

  localparam logic [ROWS-1:0] PADDLE_RST = bitmap(CENTER_P);

  // Shared sample-tick divider for every debouncer
  logic [DW-1:0] div_q, div_d;
  logic          tick;

  always_comb begin
    tick  = (div_q == DW'(DEB_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_d;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]         sync_a_q, sync_a_d, sync_b_q, sync_b_d;
    logic [DEB_LEN-1:0] hist_a_q, hist_a_d, hist_b_q, hist_b_d;
    logic               dba_q, dba_d, dbb_q, dbb_d;
    logic               dba_dly_q, dba_dly_d;
    logic               up_q, up_d, dn_q, dn_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [ROWS-1:0]    paddle_q, paddle_d;
    logic               rise, live;

    always_comb begin
      sync_a_d  = {sync_a_q[0], enc_a[i]};
      sync_b_d  = {sync_b_q[0], enc_b[i]};
      hist_a_d  = tick ? DEB_LEN'({hist_a_q, sync_a_q[1]}) : hist_a_q;
      hist_b_d  = tick ? DEB_LEN'({hist_b_q, sync_b_q[1]}) : hist_b_q;

      // Debounced level only moves on a unanimous history
      dba_d     = (&hist_a_q) ? 1'b1 : ((~|hist_a_q) ? 1'b0 : dba_q);
      dbb_d     = (&hist_b_q) ? 1'b1 : ((~|hist_b_q) ? 1'b0 : dbb_q);
      dba_dly_d = dba_q;

      rise      = dba_q & ~dba_dly_q;
      live      = ~freeze & ~recenter[i];
      up_d      = rise & ~dbb_q & live;
      dn_d      = rise &  dbb_q & live;

      pos_d = pos_q;
      if (recenter[i]) begin
        pos_d = CENTER_P;
      end else if (!freeze && rise) begin
        if (!dbb_q && (pos_q < MAXPOS_P)) pos_d = pos_q + 1'b1;
        else if (dbb_q && (pos_q != '0))  pos_d = pos_q - 1'b1;
      end

      paddle_d = bitmap(pos_q);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_a_q  <= '0;
        sync_b_q  <= '0;
        hist_a_q  <= '0;
        hist_b_q  <= '0;
        dba_q     <= 1'b0;
        dbb_q     <= 1'b0;
        dba_dly_q <= 1'b0;
        up_q      <= 1'b0;
        dn_q      <= 1'b0;
        pos_q     <= CENTER_P;
        paddle_q  <= PADDLE_RST;
      end else begin
        sync_a_q  <= sync_a_d;
        sync_b_q  <= sync_b_d;
        hist_a_q  <= hist_a_d;
        hist_b_q  <= hist_b_d;
        dba_q     <= dba_d;
        dbb_q     <= dbb_d;
        dba_dly_q <= dba_dly_d;
        up_q      <= up_d;
        dn_q      <= dn_d;
        pos_q     <= pos_d;
        paddle_q  <= paddle_d;
      end
    end

    assign step_up[i]              = up_q;
    assign step_dn[i]              = dn_q;
    assign pos[i*PW +: PW]         = pos_q;
    assign paddle_o[i*ROWS +: ROWS] = paddle_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_paddle_bank.sv
//------------------------------------------------------------------------------
// tb_paddle_bank : directed self-checking bench for paddle_bank (NCH=2, ROWS=16)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_paddle_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  enc_a, enc_b, recenter;
  logic        freeze;
  logic [1:0]  step_up, step_dn;
  logic [7:0]  pos;
  logic [31:0] paddle_o;

  int checks   = 0;
  int failures = 0;

  int up_cnt [2] = '{0, 0};
  int dn_cnt [2] = '{0, 0};
  int wide_err   = 0;
  int lag_err    = 0;
  logic [7:0] prev_pos;
  logic [1:0] prev_up, prev_dn;
  bit         prev_ok = 0;

  paddle_bank #(
    .NCH(2), .ROWS(16), .PLEN(3), .DEB_LEN(9), .DEB_DIV(7)
  ) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .recenter(recenter), .freeze(freeze), .step_up(step_up),
    .step_dn(step_dn), .pos(pos), .paddle_o(paddle_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mask(input logic [3:0] p);
    logic [15:0] m;
    m = 16'h0007;
    return m << p;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full detent per masked channel: B set first for down, then A pulse
  task automatic detent(input logic [1:0] up_m, input logic [1:0] dn_m);
    enc_b = enc_b | dn_m;
    hold(100);
    enc_a = enc_a | up_m | dn_m;
    hold(100);
    enc_a = enc_a & ~(up_m | dn_m);
    hold(100);
    enc_b = enc_b & ~dn_m;
    hold(100);
  endtask

  // Pulse counting, pulse-width and paddle-lag monitor
  always @(negedge clk) begin
    if (!reset) begin
      prev_ok = 0;
      prev_up = '0;
      prev_dn = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (step_up[c]) up_cnt[c]++;
        if (step_dn[c]) dn_cnt[c]++;
        if ((step_up[c] && prev_up[c]) || (step_dn[c] && prev_dn[c])) wide_err++;
        if (prev_ok && (paddle_o[c*16 +: 16] !== mask(prev_pos[c*4 +: 4]))) lag_err++;
      end
      prev_pos = pos;
      prev_up  = step_up;
      prev_dn  = step_dn;
      prev_ok  = 1;
    end
  end

  initial begin
    reset    = 1'b0;
    enc_a    = '0;
    enc_b    = '0;
    recenter = '0;
    freeze   = 1'b0;
    hold(3);
    #2 reset = 1'b1;
    hold(2);

    // Reset state
    check_eq("rst_pos", {24'd0, pos}, 32'h66);
    check_eq("rst_paddle", paddle_o, 32'h01C0_01C0);
    check_eq("rst_steps", {28'd0, step_up, step_dn}, 32'h0);

    // Single up detent on ch0
    detent(2'b01, 2'b00);
    check_eq("one_up_pos", {24'd0, pos}, 32'h67);
    check_eq("one_up_paddle", paddle_o, 32'h01C0_0380);
    check_eq("one_up_cnt0", up_cnt[0], 1);
    check_eq("one_up_cnt1", up_cnt[1], 0);

    // Saturation at top then bottom
    repeat (10) detent(2'b01, 2'b00);
    check_eq("sat_hi_pos", {24'd0, pos}, 32'h6D);
    check_eq("sat_hi_paddle", paddle_o, 32'h01C0_E000);
    check_eq("sat_hi_cnt", up_cnt[0], 11);
    repeat (20) detent(2'b00, 2'b01);
    check_eq("sat_lo_pos", {24'd0, pos}, 32'h60);
    check_eq("sat_lo_paddle", paddle_o, 32'h01C0_0007);
    check_eq("sat_lo_cnt", dn_cnt[0], 20);

    // Short glitch rejected
    enc_a[0] = 1'b1;
    hold(35);
    enc_a[0] = 1'b0;
    hold(150);
    check_eq("glitch_pos", {24'd0, pos}, 32'h60);
    check_eq("glitch_cnt", up_cnt[0], 11);

    // Freeze blocks a valid detent
    freeze = 1'b1;
    detent(2'b01, 2'b00);
    freeze = 1'b0;
    hold(5);
    check_eq("freeze_pos", {24'd0, pos}, 32'h60);
    check_eq("freeze_cnt", up_cnt[0], 11);

    // Recenter beats a simultaneous down detent; ch0 still steps
    repeat (4) detent(2'b10, 2'b00);
    check_eq("ch1_up_pos", {24'd0, pos}, 32'hA0);
    recenter = 2'b10;
    detent(2'b01, 2'b10);
    recenter = 2'b00;
    hold(5);
    check_eq("recenter_pos", {24'd0, pos}, 32'h61);
    check_eq("recenter_paddle", paddle_o, 32'h01C0_000E);
    check_eq("recenter_dn1", dn_cnt[1], 0);
    check_eq("recenter_up0", up_cnt[0], 12);

    // Asynchronous reset mid-debounce
    repeat (10) detent(2'b01, 2'b00);
    check_eq("pre_reset_pos", {24'd0, pos}, 32'h6B);
    enc_a[0] = 1'b1;
    hold(30);
    #2 reset = 1'b0;
    #1;
    check_eq("async_pos", {24'd0, pos}, 32'h66);
    check_eq("async_paddle", paddle_o, 32'h01C0_01C0);
    check_eq("async_steps", {28'd0, step_up, step_dn}, 32'h0);
    enc_a[0] = 1'b0;
    hold(3);
    #2 reset = 1'b1;
    hold(200);
    check_eq("post_rel_pos", {24'd0, pos}, 32'h66);
    check_eq("post_rel_cnt", up_cnt[0], 22);
    detent(2'b01, 2'b00);
    check_eq("post_rel_step", {24'd0, pos}, 32'h67);
    check_eq("post_rel_cnt2", up_cnt[0], 23);

    check_eq("pulse_width", wide_err, 0);
    check_eq("paddle_lag", lag_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
